// File: rtl/dcache_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : dcache_ctrl_if
// Description : CPU load/store bus, line-wide memory port and performance
//               counters of the data-cache controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface dcache_ctrl_if #(
    parameter int CNT_W = 16
);
    logic              cpu_rd;
    logic              cpu_wr;
    logic [31:0]       cpu_addr;
    logic [31:0]       cpu_wdata;
    logic [31:0]       cpu_rdata;
    logic              cpu_stall;
    logic              mem_req;
    logic              mem_we;
    logic [31:0]       mem_addr;
    logic [127:0]      mem_wdata;
    logic [127:0]      mem_rdata;
    logic              mem_ready;
    logic [CNT_W-1:0]  hit_count;
    logic [CNT_W-1:0]  miss_count;

    // Environment side: CPU datapath plus main memory
    modport master (
        output cpu_rd, cpu_wr, cpu_addr, cpu_wdata, mem_rdata, mem_ready,
        input  cpu_rdata, cpu_stall, mem_req, mem_we, mem_addr, mem_wdata,
               hit_count, miss_count
    );

    // Cache controller side
    modport slave (
        input  cpu_rd, cpu_wr, cpu_addr, cpu_wdata, mem_rdata, mem_ready,
        output cpu_rdata, cpu_stall, mem_req, mem_we, mem_addr, mem_wdata,
               hit_count, miss_count
    );
endinterface
`default_nettype wire

// File: rtl/dcache_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dcache_ctrl
// Description : Direct-mapped, write-back, write-allocate data-cache
//               controller with 4-word lines, miss sequencing FSM and
//               saturating hit/miss counters.
// Revision    : 1.0 - initial release
// ============================================================================
module dcache_ctrl #(
    parameter int INDEX_BITS = 4,
    parameter int CNT_W      = 16
) (
    input  wire logic    clk,
    input  wire logic    rst_n,
    dcache_ctrl_if.slave bus
);
    localparam int               c_LINES   = 1 << INDEX_BITS;
    localparam int               c_TAG_W   = 28 - INDEX_BITS;
    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2
    } state_t;

    state_t                r_state;
    logic [c_LINES-1:0]    r_valid;
    logic [c_LINES-1:0]    r_dirty;
    logic [c_TAG_W-1:0]    r_tag  [c_LINES];
    logic [127:0]          r_data [c_LINES];
    logic [CNT_W-1:0]      r_hit_cnt;
    logic [CNT_W-1:0]      r_miss_cnt;
    logic                  r_retry;

    logic [INDEX_BITS-1:0] w_index;
    logic [c_TAG_W-1:0]    w_tag;
    logic [1:0]            w_word;
    logic                  w_req;
    logic                  w_hit;
    logic                  w_store_hit;

    assign w_index     = bus.cpu_addr[INDEX_BITS+3:4];
    assign w_tag       = bus.cpu_addr[31:INDEX_BITS+4];
    assign w_word      = bus.cpu_addr[3:2];
    assign w_req       = bus.cpu_rd | bus.cpu_wr;
    assign w_hit       = r_valid[w_index] && (r_tag[w_index] == w_tag);
    // A simultaneous rd+wr is a store; the rd strobe only matters for loads.
    assign w_store_hit = (r_state == IDLE) && bus.cpu_wr && w_hit;

    assign bus.hit_count  = r_hit_cnt;
    assign bus.miss_count = r_miss_cnt;

    // Output decode from state and the addressed line (CPU holds address during stall)
    always_comb begin
        bus.cpu_stall = 1'b0;
        bus.mem_req   = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = {bus.cpu_addr[31:4], 4'h0};
        bus.mem_wdata = r_data[w_index];
        bus.cpu_rdata = r_data[w_index][{w_word, 5'b0} +: 32];
        case (r_state)
            IDLE: begin
                bus.cpu_stall = w_req & ~w_hit;
            end
            WRITEBACK: begin
                bus.cpu_stall = 1'b1;
                bus.mem_req   = 1'b1;
                bus.mem_we    = 1'b1;
                bus.mem_addr  = {r_tag[w_index], w_index, 4'h0};
            end
            ALLOCATE: begin
                bus.cpu_stall = 1'b1;
                bus.mem_req   = 1'b1;
            end
            default: begin
                bus.cpu_stall = 1'b0;
            end
        endcase
    end

    // Data and tag arrays: store-hit word writes and line fills (never reset)
    always_ff @(posedge clk) begin
        if (w_store_hit) begin
            r_data[w_index][{w_word, 5'b0} +: 32] <= bus.cpu_wdata;
        end else if (r_state == ALLOCATE && bus.mem_ready) begin
            r_data[w_index] <= bus.mem_rdata;
            r_tag[w_index]  <= w_tag;
        end
    end

    // Miss sequencing FSM with valid/dirty bookkeeping and saturating counters
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_valid    <= '0;
            r_dirty    <= '0;
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
            r_retry    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_req && w_hit) begin
                        // The replay of a just-filled miss is not a new hit
                        if (!r_retry && (~&r_hit_cnt)) begin
                            r_hit_cnt <= r_hit_cnt + c_CNT_ONE;
                        end
                        r_retry <= 1'b0;
                        if (bus.cpu_wr) begin
                            r_dirty[w_index] <= 1'b1;
                        end
                    end else if (w_req) begin
                        if (~&r_miss_cnt) begin
                            r_miss_cnt <= r_miss_cnt + c_CNT_ONE;
                        end
                        r_retry <= 1'b1;
                        r_state <= (r_valid[w_index] && r_dirty[w_index]) ? WRITEBACK : ALLOCATE;
                    end
                end
                WRITEBACK: begin
                    if (bus.mem_ready) begin
                        r_dirty[w_index] <= 1'b0;
                        r_state          <= ALLOCATE;
                    end
                end
                ALLOCATE: begin
                    if (bus.mem_ready) begin
                        r_valid[w_index] <= 1'b1;
                        r_dirty[w_index] <= 1'b0;
                        r_state          <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_dcache_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_dcache_ctrl
// Description : Self-checking bench for dcache_ctrl; an architectural cache
//               model plus a backing-memory image predict every response.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dcache_ctrl;
    localparam int IB = 4;
    localparam int CW = 16;
    localparam int NL = 1 << IB;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   vectors = 0;
    int   errors  = 0;

    dcache_ctrl_if #(.CNT_W(CW)) bus ();

    dcache_ctrl #(.INDEX_BITS(IB), .CNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model: what each cache line holds, plus main memory contents
    bit           m_valid     [NL];
    bit           m_dirty     [NL];
    logic [31:0]  m_line_addr [NL];
    logic [31:0]  m_words     [NL][4];
    logic [127:0] mem_img     [bit [31:0]];
    int           m_hits;
    int           m_misses;

    function automatic logic [127:0] backing_line(input logic [31:0] la);
        if (!mem_img.exists(la))
            mem_img[la] = {$urandom(), $urandom(), $urandom(), $urandom()};
        return mem_img[la];
    endfunction

    function automatic int sat_inc(input int v);
        return (v >= CNT_MAX) ? v : v + 1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NL; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
        m_hits   = 0;
        m_misses = 0;
    endtask

    // One complete CPU access, starting and ending 1 time unit after a posedge.
    task automatic do_access(input bit rd, input bit wr, input logic [31:0] addr,
                             input logic [31:0] wd, input string nm);
        int           idx;
        int           w;
        logic [31:0]  la;
        bit           hit;
        logic [127:0] line;
        logic [31:0]  exp_rd;
        idx = int'(addr[IB+3:4]);
        w   = int'(addr[3:2]);
        la  = {addr[31:4], 4'h0};
        hit = m_valid[idx] && (m_line_addr[idx] == la);
        bus.cpu_rd = rd; bus.cpu_wr = wr; bus.cpu_addr = addr; bus.cpu_wdata = wd;
        if (!hit) begin
            @(negedge clk);
            vectors++;
            if (bus.cpu_stall !== 1'b1) begin
                errors++;
                $display("FAIL %s miss_stall: got %b want 1", nm, bus.cpu_stall);
            end
            m_misses = sat_inc(m_misses);
            @(posedge clk); #1;
            for (int ph = 0; ph < 2; ph++) begin
                bit           wb;
                logic [31:0]  ea;
                logic [127:0] ewd;
                int           dly;
                wb = (ph == 0);
                if (wb && !(m_valid[idx] && m_dirty[idx])) continue;
                ea  = wb ? m_line_addr[idx] : la;
                ewd = {m_words[idx][3], m_words[idx][2], m_words[idx][1], m_words[idx][0]};
                dly = $urandom_range(0, 2);
                for (int c = 0; c <= dly; c++) begin
                    @(negedge clk);
                    vectors++;
                    if (bus.mem_req !== 1'b1 || bus.mem_we !== wb || bus.mem_addr !== ea ||
                        bus.cpu_stall !== 1'b1) begin
                        errors++;
                        $display("FAIL %s mem_cmd: got req=%b we=%b addr=%h stall=%b want req=1 we=%b addr=%h stall=1",
                                 nm, bus.mem_req, bus.mem_we, bus.mem_addr, bus.cpu_stall, wb, ea);
                    end
                    if (wb) begin
                        vectors++;
                        if (bus.mem_wdata !== ewd) begin
                            errors++;
                            $display("FAIL %s wb_data: got %h want %h", nm, bus.mem_wdata, ewd);
                        end
                    end
                    if (c == dly) begin
                        // During write-back the read bus carries junk that must be ignored
                        bus.mem_rdata = wb ? {$urandom(), $urandom(), $urandom(), $urandom()}
                                           : backing_line(la);
                        bus.mem_ready = 1'b1;
                    end
                end
                @(posedge clk); #1;
                bus.mem_ready = 1'b0;
                if (wb) begin
                    mem_img[ea]  = ewd;
                    m_dirty[idx] = 1'b0;
                end else begin
                    line = backing_line(la);
                    for (int k = 0; k < 4; k++) m_words[idx][k] = line[32*k +: 32];
                    m_valid[idx]     = 1'b1;
                    m_dirty[idx]     = 1'b0;
                    m_line_addr[idx] = la;
                end
            end
        end else begin
            m_hits = sat_inc(m_hits);
        end
        // Hit cycle (original hit or replay after the fill)
        @(negedge clk);
        exp_rd = m_words[idx][w];
        vectors++;
        if (bus.cpu_stall !== 1'b0) begin
            errors++;
            $display("FAIL %s hit_stall: got %b want 0", nm, bus.cpu_stall);
        end
        if (rd && !wr) begin
            vectors++;
            if (bus.cpu_rdata !== exp_rd) begin
                errors++;
                $display("FAIL %s rdata @%h: got %h want %h", nm, addr, bus.cpu_rdata, exp_rd);
            end
        end
        @(posedge clk); #1;
        bus.cpu_rd = 1'b0; bus.cpu_wr = 1'b0;
        if (wr) begin
            m_words[idx][w] = wd;
            m_dirty[idx]    = 1'b1;
        end
        vectors++;
        if (bus.hit_count !== CW'(m_hits) || bus.miss_count !== CW'(m_misses)) begin
            errors++;
            $display("FAIL %s counters: got hit=%0d miss=%0d want hit=%0d miss=%0d",
                     nm, bus.hit_count, bus.miss_count, m_hits, m_misses);
        end
    endtask

    task automatic test_reset();
        bus.cpu_rd = 1'b0; bus.cpu_wr = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        bus.mem_rdata = '0; bus.mem_ready = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        vectors++;
        if (bus.cpu_stall !== 1'b0 || bus.mem_req !== 1'b0 || bus.mem_we !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got stall=%b req=%b we=%b want 0 0 0",
                     bus.cpu_stall, bus.mem_req, bus.mem_we);
        end
        vectors++;
        if (bus.hit_count !== '0 || bus.miss_count !== '0) begin
            errors++;
            $display("FAIL reset_counters: got hit=%0d miss=%0d want 0 0", bus.hit_count, bus.miss_count);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_cold_fill();
        mem_img[32'h10] = {32'hD, 32'hC, 32'hB, 32'hA};
        do_access(1'b1, 1'b0, 32'h10, 32'h0, "cold_fill");
    endtask

    task automatic test_hit();
        do_access(1'b1, 1'b0, 32'h1C, 32'h0, "load_hit");
    endtask

    task automatic test_writeback();
        do_access(1'b0, 1'b1, 32'h14, 32'h12345678, "store_hit");
        do_access(1'b0, 1'b1, 32'h114, 32'h0BADBEEF, "store_miss_wb");
        do_access(1'b1, 1'b0, 32'h114, 32'h0, "load_after_alloc");
        do_access(1'b1, 1'b0, 32'h14, 32'h0, "reload_written_back");
    endtask

    task automatic test_rd_wr_both();
        do_access(1'b1, 1'b1, 32'h18, 32'hCAFEF00D, "rd_wr_store");
        do_access(1'b1, 1'b0, 32'h218, 32'h0, "evict_dirty");
        do_access(1'b1, 1'b0, 32'h18, 32'h0, "refetch_stored");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 160; i++) begin
            logic [31:0] a;
            int          kind;
            a    = ($urandom_range(0, 3) << 8) | ($urandom_range(0, NL-1) << 4) | ($urandom_range(0, 3) << 2);
            kind = $urandom_range(0, 2);
            do_access(kind != 1, kind != 0, a, $urandom(), "random");
        end
    endtask

    task automatic test_reset_mid();
        test_reset();
        bus.cpu_rd = 1'b1; bus.cpu_wr = 1'b0; bus.cpu_addr = 32'hF4;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        vectors++;
        if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== 32'hF0) begin
            errors++;
            $display("FAIL alloc_before_reset: got req=%b we=%b addr=%h want 1 0 000000f0",
                     bus.mem_req, bus.mem_we, bus.mem_addr);
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus.cpu_rd = 1'b0;
        model_reset();
        @(negedge clk);
        vectors++;
        if (bus.mem_req !== 1'b0 || bus.cpu_stall !== 1'b0 || bus.miss_count !== '0) begin
            errors++;
            $display("FAIL reset_mid_txn: got req=%b stall=%b miss=%0d want 0 0 0",
                     bus.mem_req, bus.cpu_stall, bus.miss_count);
        end
        @(posedge clk); #1;
        do_access(1'b1, 1'b0, 32'hF4, 32'h0, "miss_after_reset");
    endtask

    task automatic test_saturate();
        int n;
        n = 16'hFFFE - m_hits;
        bus.cpu_rd = 1'b1; bus.cpu_wr = 1'b0; bus.cpu_addr = 32'hF8;
        repeat (n) @(posedge clk);
        #1;
        vectors++;
        if (bus.hit_count !== 16'hFFFE || bus.cpu_stall !== 1'b0) begin
            errors++;
            $display("FAIL hit_near_sat: got %h stall=%b want fffe stall=0", bus.hit_count, bus.cpu_stall);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            vectors++;
            if (bus.hit_count !== 16'hFFFF) begin
                errors++;
                $display("FAIL hit_saturate[%0d]: got %h want ffff", i, bus.hit_count);
            end
        end
        bus.cpu_rd = 1'b0;
        vectors++;
        if (bus.miss_count !== CW'(m_misses)) begin
            errors++;
            $display("FAIL miss_during_sat: got %0d want %0d", bus.miss_count, m_misses);
        end
    endtask

    initial begin
        test_reset();
        test_cold_fill();
        test_hit();
        test_writeback();
        test_rd_wr_both();
        test_back_to_back();
        test_reset_mid();
        test_saturate();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
`default_nettype wire
